// File: rtl/uart_bridge_pkg.sv
// Shared types and width helpers for the UART <-> word-memory bridge.
// Holds the TX serialiser state encoding and index/counter width helpers.
package uart_bridge_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_FETCH,
      TX_WAIT,
      TX_LOAD,
      TX_ISSUE,
      TX_ACK,
      TX_DRAIN
   } tx_state_t;

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_word_bridge_phy.sv
// 8N1 UART byte cores: one receiver and one transmitter sharing a bit timer width.
// Ports: clk, reset (sync, active high), rxd/txd serial lines,
//   tx_start/tx_byte/tx_busy byte send side, rx_busy/rx_byte byte receive side.
module uart_word_bridge_phy
   import uart_bridge_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rxd,
   output logic              txd,
   input  logic              tx_start,
   input  logic [BYTE_W-1:0] tx_byte,
   output logic              tx_busy,
   output logic              rx_busy,
   output logic [BYTE_W-1:0] rx_byte
);

   localparam int CW = idx_w(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

   // Receiver: rx_busy only rises once the start bit is confirmed at
   // mid-bit, so a line glitch never produces a busy fall.
   logic [1:0]    sync;
   logic          rx_act;
   logic [3:0]    rx_bit;
   logic [CW-1:0] rx_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync    <= 2'b11;
         rx_act  <= 1'b0;
         rx_busy <= 1'b0;
         rx_bit  <= '0;
         rx_cnt  <= '0;
         rx_byte <= '0;
      end else begin
         sync <= {sync[0], rxd};
         if (!rx_act) begin
            if (!sync[1]) begin
               rx_act <= 1'b1;
               rx_bit <= '0;
               rx_cnt <= HALF_BIT;
            end
         end else if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
         end else begin
            rx_cnt <= BIT_LAST;
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 4'd0) begin
               if (sync[1]) rx_act <= 1'b0;
               else         rx_busy <= 1'b1;
            end else if (rx_bit == 4'd9) begin
               rx_act  <= 1'b0;
               rx_busy <= 1'b0;
            end else begin
               rx_byte <= {sync[1], rx_byte[7:1]};
            end
         end
      end
   end

   // Transmitter: start, 8 data bits LSB first, stop; idle line high.
   logic [9:0]    tx_sh;
   logic [3:0]    tx_bit;
   logic [CW-1:0] tx_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_sh   <= '1;
         tx_busy <= 1'b0;
         tx_bit  <= '0;
         tx_cnt  <= '0;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_sh   <= {1'b1, tx_byte, 1'b0};
            tx_busy <= 1'b1;
            tx_bit  <= '0;
            tx_cnt  <= BIT_LAST;
         end
      end else if (tx_cnt != '0) begin
         tx_cnt <= tx_cnt - 1'b1;
      end else begin
         tx_cnt <= BIT_LAST;
         tx_sh  <= {1'b1, tx_sh[9:1]};
         tx_bit <= tx_bit + 1'b1;
         if (tx_bit == 4'd9) tx_busy <= 1'b0;
      end
   end

   assign txd = tx_sh[0];

endmodule

// File: rtl/uart_word_bridge.sv
// UART <-> memory bridge: packs RX bytes into words for a sample RAM and
// serialises result-RAM words onto the UART, LSB byte first.
// Ports: CLOCK_50/RESET; UART_RXD/UART_TXD; START/STOP arm RX capture;
//   wr_en/wr_address/wr_data/wr_full/rx_err write side;
//   TX_EN/rd_en/rd_address/rd_data/tx_busy/tx_done read side.
module uart_word_bridge
   import uart_bridge_pkg::*;
#(
   parameter int RX_BYTES     = 2,
   parameter int TX_BYTES     = 5,
   parameter int WR_AW        = 14,
   parameter int RD_AW        = 10,
   parameter int RD_LATENCY   = 1,
   parameter int RX_TIMEOUT   = 50000,
   parameter int WR_WRAP      = 1,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                       CLOCK_50,
   input  logic                       RESET,
   input  logic                       UART_RXD,
   output logic                       UART_TXD,
   input  logic                       START,
   input  logic                       STOP,
   output logic                       wr_en,
   output logic [WR_AW-1:0]           wr_address,
   output logic [BYTE_W*RX_BYTES-1:0] wr_data,
   output logic                       wr_full,
   output logic                       rx_err,
   input  logic                       TX_EN,
   output logic                       rd_en,
   output logic [RD_AW-1:0]           rd_address,
   input  logic [BYTE_W*TX_BYTES-1:0] rd_data,
   output logic                       tx_busy,
   output logic                       tx_done
);

   localparam int IW = idx_w(RX_BYTES);
   localparam int TW = idx_w(RX_TIMEOUT);
   localparam int KW = idx_w(TX_BYTES);
   localparam int LW = idx_w(RD_LATENCY);

   localparam logic [IW-1:0]    RX_LAST  = IW'(RX_BYTES - 1);
   localparam logic [TW-1:0]    TMO_LAST = TW'(RX_TIMEOUT - 1);
   localparam logic [KW-1:0]    TX_LAST  = KW'(TX_BYTES - 1);
   localparam logic [LW-1:0]    LAT_LAST = LW'(RD_LATENCY - 1);
   localparam logic [WR_AW-1:0] WR_MAX   = '1;

   logic              core_tx_start;
   logic [BYTE_W-1:0] core_tx_byte;
   logic              core_tx_busy;
   logic              core_rx_busy;
   logic [BYTE_W-1:0] core_rx_byte;

   uart_word_bridge_phy #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_phy (
      .clk      (CLOCK_50),
      .reset    (RESET),
      .rxd      (UART_RXD),
      .txd      (UART_TXD),
      .tx_start (core_tx_start),
      .tx_byte  (core_tx_byte),
      .tx_busy  (core_tx_busy),
      .rx_busy  (core_rx_busy),
      .rx_byte  (core_rx_byte)
   );

   // RX packer
   logic          rx_busy_q;
   logic          rx_valid;
   logic          armed;
   logic [IW-1:0] idx;
   logic [TW-1:0] timer;

   assign rx_valid = rx_busy_q && !core_rx_busy;

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         rx_busy_q  <= 1'b0;
         armed      <= 1'b0;
         idx        <= '0;
         timer      <= '0;
         wr_en      <= 1'b0;
         wr_address <= '0;
         wr_data    <= '0;
         wr_full    <= 1'b0;
         rx_err     <= 1'b0;
      end else begin
         rx_busy_q <= core_rx_busy;
         wr_en     <= 1'b0;
         rx_err    <= 1'b0;
         // Address advances the cycle after the strobe.
         if (wr_en) begin
            if (WR_WRAP != 0)           wr_address <= wr_address + 1'b1;
            else if (wr_address == WR_MAX) wr_full <= 1'b1;
            else                        wr_address <= wr_address + 1'b1;
         end
         if (STOP) begin
            armed   <= 1'b0;
            idx     <= '0;
            timer   <= '0;
            wr_data <= '0;
         end else begin
            if (START) armed <= 1'b1;
            // A byte landing on the timeout cycle wins.
            if (rx_valid && armed) begin
               wr_data[BYTE_W*idx +: BYTE_W] <= core_rx_byte;
               timer <= '0;
               if (idx == RX_LAST) begin
                  idx   <= '0;
                  wr_en <= !wr_full;
               end else begin
                  idx <= idx + 1'b1;
               end
            end else if (idx != '0) begin
               if (timer == TMO_LAST) begin
                  idx    <= '0;
                  timer  <= '0;
                  rx_err <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end else begin
               timer <= '0;
            end
         end
      end
   end

   // TX serialiser
   tx_state_t                  state, state_n;
   logic [KW-1:0]              k, k_n;
   logic [LW-1:0]              wcnt, wcnt_n;
   logic [BYTE_W*TX_BYTES-1:0] word, word_n;
   logic [RD_AW-1:0]           rd_addr_n;

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state      <= TX_IDLE;
         k          <= '0;
         wcnt       <= '0;
         word       <= '0;
         rd_address <= '0;
      end else begin
         state      <= state_n;
         k          <= k_n;
         wcnt       <= wcnt_n;
         word       <= word_n;
         rd_address <= rd_addr_n;
      end
   end

   always_comb begin
      state_n       = state;
      k_n           = k;
      wcnt_n        = wcnt;
      word_n        = word;
      rd_addr_n     = rd_address;
      rd_en         = 1'b0;
      core_tx_start = 1'b0;
      tx_done       = 1'b0;
      unique case (state)
         TX_IDLE:  if (TX_EN) state_n = TX_FETCH;
         TX_FETCH: begin
            rd_en   = 1'b1;
            wcnt_n  = '0;
            state_n = TX_WAIT;
         end
         TX_WAIT: begin
            if (wcnt == LAT_LAST) state_n = TX_LOAD;
            else                  wcnt_n  = wcnt + 1'b1;
         end
         TX_LOAD: begin
            word_n  = rd_data;
            k_n     = '0;
            state_n = TX_ISSUE;
         end
         TX_ISSUE: begin
            if (!core_tx_busy) begin
               core_tx_start = 1'b1;
               state_n       = TX_ACK;
            end
         end
         TX_ACK: if (core_tx_busy) state_n = TX_DRAIN;
         TX_DRAIN: begin
            if (!core_tx_busy) begin
               if (k != TX_LAST) begin
                  k_n     = k + 1'b1;
                  state_n = TX_ISSUE;
               end else begin
                  tx_done   = 1'b1;
                  rd_addr_n = rd_address + 1'b1;
                  state_n   = TX_EN ? TX_FETCH : TX_IDLE;
               end
            end
         end
         default: state_n = TX_IDLE;
      endcase
   end

   // Word and k only change at LOAD and DRAIN exit, so the byte is stable.
   assign core_tx_byte = word[BYTE_W*k +: BYTE_W];
   assign tx_busy      = (state != TX_IDLE);

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge: two instances (saturating / latency 1
// and wrapping / latency 3) share stimulus; outputs are checked per instance.
module tb_uart_word_bridge;

   localparam int CPB = 8;
   localparam int TMO = 200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic RESET, UART_RXD, START, STOP, TX_EN;

   logic        txd_a, wr_en_a, wr_full_a, rx_err_a;
   logic        rd_en_a, tx_busy_a, tx_done_a;
   logic [1:0]  wr_address_a;
   logic [15:0] wr_data_a;
   logic [3:0]  rd_address_a;
   logic [39:0] rd_data_a;

   logic        txd_b, wr_en_b, wr_full_b, rx_err_b;
   logic        rd_en_b, tx_busy_b, tx_done_b;
   logic [1:0]  wr_address_b;
   logic [15:0] wr_data_b;
   logic [3:0]  rd_address_b;
   logic [39:0] rd_data_b;

   uart_word_bridge #(
      .RX_BYTES(2), .TX_BYTES(5), .WR_AW(2), .RD_AW(4),
      .RD_LATENCY(1), .RX_TIMEOUT(TMO), .WR_WRAP(0), .CLKS_PER_BIT(CPB)
   ) dut_a (
      .CLOCK_50(clk), .RESET(RESET), .UART_RXD(UART_RXD), .UART_TXD(txd_a),
      .START(START), .STOP(STOP), .wr_en(wr_en_a), .wr_address(wr_address_a),
      .wr_data(wr_data_a), .wr_full(wr_full_a), .rx_err(rx_err_a),
      .TX_EN(TX_EN), .rd_en(rd_en_a), .rd_address(rd_address_a),
      .rd_data(rd_data_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a)
   );

   uart_word_bridge #(
      .RX_BYTES(2), .TX_BYTES(5), .WR_AW(2), .RD_AW(4),
      .RD_LATENCY(3), .RX_TIMEOUT(TMO), .WR_WRAP(1), .CLKS_PER_BIT(CPB)
   ) dut_b (
      .CLOCK_50(clk), .RESET(RESET), .UART_RXD(UART_RXD), .UART_TXD(txd_b),
      .START(START), .STOP(STOP), .wr_en(wr_en_b), .wr_address(wr_address_b),
      .wr_data(wr_data_b), .wr_full(wr_full_b), .rx_err(rx_err_b),
      .TX_EN(TX_EN), .rd_en(rd_en_b), .rd_address(rd_address_b),
      .rd_data(rd_data_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b)
   );

   // Result RAM contents: byte i of word a is a*5+i+1.
   function automatic logic [39:0] word_of(input logic [3:0] a);
      logic [39:0] w;
      for (int i = 0; i < 5; i++) w[8*i +: 8] = 8'(int'(a) * 5 + i + 1);
      return w;
   endfunction

   // Latency-1 RAM, output held until the next read.
   always @(posedge clk) if (rd_en_a) rd_data_a <= word_of(rd_address_a);

   // Latency-3 RAM: output is junk until the third edge after the read.
   logic [1:0] pb;
   logic [3:0] ab;
   always @(posedge clk) begin
      pb <= {pb[0], rd_en_b};
      if (rd_en_b) ab <= rd_address_b;
      if (pb[1])        rd_data_b <= word_of(ab);
      else if (rd_en_b) rd_data_b <= 40'hEE_DD_CC_BB_AA;
   end

   // Write / pulse monitors
   logic [17:0] wa[$];
   logic [17:0] wb[$];
   int erra = 0, errb = 0, donea = 0, doneb = 0;

   always @(negedge clk) begin
      if (wr_en_a === 1'b1) wa.push_back({wr_address_a, wr_data_a});
      if (wr_en_b === 1'b1) wb.push_back({wr_address_b, wr_data_b});
      if (rx_err_a === 1'b1) erra++;
      if (rx_err_b === 1'b1) errb++;
      if (tx_done_a === 1'b1) donea++;
      if (tx_done_b === 1'b1) doneb++;
   end

   // Serial decoders for both UART_TXD lines
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] ba, bb;

   always begin
      @(negedge clk);
      if (txd_a === 1'b0) begin
         repeat (CPB / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            ba[i] = txd_a;
         end
         repeat (CPB) @(negedge clk);
         qa.push_back(ba);
      end
   end

   always begin
      @(negedge clk);
      if (txd_b === 1'b0) begin
         repeat (CPB / 2) @(negedge clk);
         for (int j = 0; j < 8; j++) begin
            repeat (CPB) @(negedge clk);
            bb[j] = txd_b;
         end
         repeat (CPB) @(negedge clk);
         qb.push_back(bb);
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      UART_RXD = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         UART_RXD = b[i];
         repeat (CPB) @(negedge clk);
      end
      UART_RXD = 1'b1;
      repeat (3 * CPB) @(negedge clk);
   endtask

   task automatic pulse_start();
      START = 1'b1;
      @(negedge clk);
      START = 1'b0;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      repeat (2) @(negedge clk);
      RESET = 1'b0;
      wa.delete();
      wb.delete();
   endtask

   int e0a, e0b, d0a, d0b;

   initial begin
      RESET    = 1'b1;
      UART_RXD = 1'b1;
      START    = 1'b0;
      STOP     = 1'b0;
      TX_EN    = 1'b0;
      repeat (4) @(negedge clk);

      // Reset state: {wr_en,wr_address,wr_full,rx_err,rd_en,rd_address,tx_busy,tx_done,txd}
      chk("reset_a", {wr_en_a, wr_address_a, wr_full_a, rx_err_a, rd_en_a,
                      rd_address_a, tx_busy_a, tx_done_a, txd_a, wr_data_a}, {13'h1, 16'h0});
      chk("reset_b", {wr_en_b, wr_address_b, wr_full_b, rx_err_b, rd_en_b,
                      rd_address_b, tx_busy_b, tx_done_b, txd_b, wr_data_b}, {13'h1, 16'h0});
      RESET = 1'b0;
      @(negedge clk);

      // Armed pair -> one write of 0x1234 at address 0
      pulse_start();
      send_byte(8'h34);
      send_byte(8'h12);
      repeat (20) @(negedge clk);
      chk("pair_count_a", wa.size(), 1);
      chk("pair_word_a", wa[0], {2'd0, 16'h1234});
      chk("pair_addr_a", wr_address_a, 1);
      chk("pair_word_b", {wb.size(), wb[0]}, {32'd1, 2'd0, 16'h1234});

      // Unarmed bytes dropped, then armed pair
      do_reset();
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      chk("unarmed_none", wa.size() + wb.size(), 0);
      pulse_start();
      send_byte(8'hAA);
      send_byte(8'h55);
      repeat (20) @(negedge clk);
      chk("armed_count_a", wa.size(), 1);
      chk("armed_word_a", wa[0], {2'd0, 16'h55AA});

      // Partial word timeout
      e0a = erra;
      e0b = errb;
      send_byte(8'h77);
      repeat (TMO + 60) @(negedge clk);
      chk("tmo_err_a", erra - e0a, 1);
      chk("tmo_err_b", errb - e0b, 1);
      chk("tmo_nowrite", wa.size() + wb.size(), 2);
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (20) @(negedge clk);
      chk("after_tmo_a", {wa.size(), wa[1]}, {32'd2, 2'd1, 16'h2211});
      chk("after_tmo_err", erra - e0a, 1);

      // Five words into a 4-deep window: saturate (a) vs wrap (b)
      do_reset();
      pulse_start();
      for (int w = 0; w < 5; w++) begin
         send_byte(8'hB0 + 8'(w));
         send_byte(8'hA0 + 8'(w));
      end
      repeat (20) @(negedge clk);
      chk("sat_count_a", wa.size(), 4);
      chk("sat_last_a", wa[3], {2'd3, 16'hA3B3});
      chk("sat_full_a", {wr_full_a, wr_address_a}, {1'b1, 2'd3});
      chk("wrap_count_b", wb.size(), 5);
      chk("wrap_fifth_b", wb[4], {2'd0, 16'hA4B4});
      chk("wrap_state_b", {wr_full_b, wr_address_b}, {1'b0, 2'd1});

      // One word out; TX_EN dropped during the second byte
      qa.delete();
      qb.delete();
      d0a = donea;
      d0b = doneb;
      TX_EN = 1'b1;
      for (int i = 0; i < 3000 && (qa.size() < 1 || qb.size() < 1); i++) @(negedge clk);
      repeat (30) @(negedge clk);
      TX_EN = 1'b0;
      for (int i = 0; i < 3000 && (qa.size() < 5 || qb.size() < 5); i++) @(negedge clk);
      repeat (200) @(negedge clk);
      chk("tx1_count_a", qa.size(), 5);
      chk("tx1_bytes_a", {qa[4], qa[3], qa[2], qa[1], qa[0]}, 40'h0504030201);
      chk("tx1_done_a", donea - d0a, 1);
      chk("tx1_state_a", {tx_busy_a, rd_address_a}, {1'b0, 4'd1});
      chk("tx1_count_b", qb.size(), 5);
      chk("tx1_bytes_b", {qb[4], qb[3], qb[2], qb[1], qb[0]}, 40'h0504030201);
      chk("tx1_done_b", doneb - d0b, 1);
      chk("tx1_state_b", {tx_busy_b, rd_address_b}, {1'b0, 4'd1});

      // Streaming run interrupted by reset
      qa.delete();
      qb.delete();
      TX_EN = 1'b1;
      for (int i = 0; i < 4000 && (qa.size() < 6 || qb.size() < 6); i++) @(negedge clk);
      chk("tx2_bytes_a", {qa[5], qa[4], qa[3], qa[2], qa[1], qa[0]}, 48'h0B0A09080706);
      chk("tx2_bytes_b", {qb[5], qb[4], qb[3], qb[2], qb[1], qb[0]}, 48'h0B0A09080706);
      repeat (20) @(negedge clk);
      RESET = 1'b1;
      @(negedge clk);
      chk("rst_mid_a", {tx_busy_a, rd_en_a, rd_address_a}, 6'd0);
      chk("rst_mid_b", {tx_busy_b, rd_en_b, rd_address_b}, 6'd0);
      TX_EN = 1'b0;
      @(negedge clk);
      RESET = 1'b0;
      repeat (12 * CPB) @(negedge clk);
      qa.delete();
      qb.delete();
      d0a = donea;
      d0b = doneb;
      repeat (40 * CPB) @(negedge clk);
      chk("rst_quiet_a", {qa.size(), donea - d0a, tx_busy_a, txd_a}, {64'd1});
      chk("rst_quiet_b", {qb.size(), doneb - d0b, tx_busy_b, txd_b}, {64'd1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
